// File: rtl/fetch_mem_arb.sv
// fetch_mem_arb: round-robin arbiter sharing one instruction-memory port between two fetch requesters.
// Optional macro FETCH_MEM_ARB_ERR_EN adds a sticky ERR output flagging responses with nothing outstanding.
module fetch_mem_arb #(
  parameter int OUTST = 4,
  parameter int PCW   = 32,
  parameter int IW    = 32
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           F0_REQV,
  input  logic [PCW-1:0] F0_PC,
  output logic           F0_REQINV,
  output logic           F0_RSPV,
  output logic           F0_RSPINV,
  output logic [IW-1:0]  F0_INSTR,
  input  logic           F1_REQV,
  input  logic [PCW-1:0] F1_PC,
  output logic           F1_REQINV,
  output logic           F1_RSPV,
  output logic           F1_RSPINV,
  output logic [IW-1:0]  F1_INSTR,
  output logic           M_REQV,
  output logic [PCW-1:0] M_PC,
  input  logic           M_REQINV,
  input  logic           M_RSPV,
  input  logic           M_RSPINV,
  input  logic [IW-1:0]  M_INSTR
`ifdef FETCH_MEM_ARB_ERR_EN
  ,
  output logic           ERR
`endif
);

  localparam int CW = $clog2(OUTST + 1);
  localparam int PW = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTST);
  localparam logic [PW-1:0] LAST_PTR = PW'(OUTST - 1);

  logic             rr_r;
  logic [OUTST-1:0] fifo_r;
  logic [PW-1:0]    wptr_r;
  logic [PW-1:0]    rptr_r;
  logic [CW-1:0]    count_r;

  logic full_s;
  logic empty_s;
  logic win_v_s;
  logic win_id_s;
  logic push_s;
  logic pop_s;
  logic head_s;

  // Pointers wrap at OUTST-1 so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = p + PW'(1'b1);
    end
  endfunction

  // Winner selection; full is based on registered count so M_RSPV never reaches REQINV.
  always_comb begin
    full_s   = (count_r == FULL_CNT);
    empty_s  = (count_r == {CW{1'b0}});
    win_v_s  = 1'b0;
    win_id_s = 1'b0;
    if (full_s) begin
      win_v_s  = 1'b0;
      win_id_s = 1'b0;
    end else if (F0_REQV && F1_REQV) begin
      win_v_s  = 1'b1;
      win_id_s = rr_r;
    end else if (F1_REQV) begin
      win_v_s  = 1'b1;
      win_id_s = 1'b1;
    end else if (F0_REQV) begin
      win_v_s  = 1'b1;
      win_id_s = 1'b0;
    end else begin
      win_v_s  = 1'b0;
      win_id_s = 1'b0;
    end
    push_s = win_v_s & ~M_REQINV;
    pop_s  = M_RSPV & ~empty_s;
    head_s = fifo_r[rptr_r];
  end

  // Output drive; reset forces the request/response handshake idle.
  always_comb begin
    M_PC     = win_id_s ? F1_PC : F0_PC;
    F0_INSTR = M_INSTR;
    F1_INSTR = M_INSTR;
    if (!RSTN) begin
      M_REQV    = 1'b0;
      F0_REQINV = 1'b1;
      F1_REQINV = 1'b1;
      F0_RSPV   = 1'b0;
      F1_RSPV   = 1'b0;
    end else begin
      M_REQV    = win_v_s;
      F0_REQINV = (win_v_s && !win_id_s) ? M_REQINV : 1'b1;
      F1_REQINV = (win_v_s &&  win_id_s) ? M_REQINV : 1'b1;
      F0_RSPV   = pop_s & ~head_s;
      F1_RSPV   = pop_s &  head_s;
    end
    F0_RSPINV = F0_RSPV & M_RSPINV;
    F1_RSPINV = F1_RSPV & M_RSPINV;
  end

  // Arbitration pointer and ID FIFO state.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      rr_r    <= 1'b0;
      fifo_r  <= {OUTST{1'b0}};
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        fifo_r[wptr_r] <= win_id_s;
        wptr_r         <= ptr_inc(wptr_r);
        rr_r           <= ~win_id_s;
      end
      if (pop_s) begin
        rptr_r <= ptr_inc(rptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef FETCH_MEM_ARB_ERR_EN
  // Sticky flag for a memory response that arrives with no request outstanding.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      ERR <= 1'b0;
    end else if (M_RSPV && empty_s) begin
      ERR <= 1'b1;
    end else begin
      ERR <= ERR;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_mem_arb.sv
// Directed bench for fetch_mem_arb: queue-based reference model checked every cycle plus literal spot checks.
module tb_fetch_mem_arb;
  localparam int OUTST = 4;
  localparam int PCW   = 32;
  localparam int IW    = 32;

  logic           CLK = 1'b0;
  logic           RSTN;
  logic           F0_REQV, F1_REQV, M_REQINV, M_RSPV, M_RSPINV;
  logic [PCW-1:0] F0_PC, F1_PC, M_PC;
  logic [IW-1:0]  M_INSTR, F0_INSTR, F1_INSTR;
  logic           F0_REQINV, F0_RSPV, F0_RSPINV;
  logic           F1_REQINV, F1_RSPV, F1_RSPINV;
  logic           M_REQV;
`ifdef FETCH_MEM_ARB_ERR_EN
  logic           ERR;
`endif

  int n_vec = 0;
  int n_bad = 0;

  fetch_mem_arb #(.OUTST(OUTST), .PCW(PCW), .IW(IW)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .F0_REQV(F0_REQV), .F0_PC(F0_PC), .F0_REQINV(F0_REQINV),
    .F0_RSPV(F0_RSPV), .F0_RSPINV(F0_RSPINV), .F0_INSTR(F0_INSTR),
    .F1_REQV(F1_REQV), .F1_PC(F1_PC), .F1_REQINV(F1_REQINV),
    .F1_RSPV(F1_RSPV), .F1_RSPINV(F1_RSPINV), .F1_INSTR(F1_INSTR),
    .M_REQV(M_REQV), .M_PC(M_PC), .M_REQINV(M_REQINV),
    .M_RSPV(M_RSPV), .M_RSPINV(M_RSPINV), .M_INSTR(M_INSTR)
`ifdef FETCH_MEM_ARB_ERR_EN
    , .ERR(ERR)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of requester IDs awaiting responses, preferred requester, sticky error.
  bit   mq[$];
  bit   m_rr = 1'b0;
  bit   m_err = 1'b0;
  bit   s_acc, s_win, s_pop, s_stray;

  always @(negedge CLK) begin
    bit full, v, w, pop, head;
    bit e_mreqv, e_f0inv, e_f1inv, e_f0rsp, e_f1rsp;
    logic [PCW-1:0] e_pc;
    full = (mq.size() == OUTST);
    v = 1'b0;
    w = 1'b0;
    if (!full) begin
      if (F0_REQV && F1_REQV) begin v = 1'b1; w = m_rr; end
      else if (F0_REQV)       begin v = 1'b1; w = 1'b0; end
      else if (F1_REQV)       begin v = 1'b1; w = 1'b1; end
    end
    pop  = M_RSPV && (mq.size() > 0);
    head = pop ? mq[0] : 1'b0;
    e_mreqv = RSTN && v;
    e_pc    = (v && w) ? F1_PC : F0_PC;
    e_f0inv = !RSTN ? 1'b1 : ((v && !w) ? M_REQINV : 1'b1);
    e_f1inv = !RSTN ? 1'b1 : ((v &&  w) ? M_REQINV : 1'b1);
    e_f0rsp = RSTN && pop && !head;
    e_f1rsp = RSTN && pop &&  head;
    chk("m_reqv",    M_REQV,    e_mreqv);
    chk("m_pc",      M_PC,      e_pc);
    chk("f0_reqinv", F0_REQINV, e_f0inv);
    chk("f1_reqinv", F1_REQINV, e_f1inv);
    chk("f0_rspv",   F0_RSPV,   e_f0rsp);
    chk("f1_rspv",   F1_RSPV,   e_f1rsp);
    chk("f0_rspinv", F0_RSPINV, e_f0rsp && M_RSPINV);
    chk("f1_rspinv", F1_RSPINV, e_f1rsp && M_RSPINV);
    chk("f0_instr",  F0_INSTR,  M_INSTR);
    chk("f1_instr",  F1_INSTR,  M_INSTR);
`ifdef FETCH_MEM_ARB_ERR_EN
    chk("err",       ERR,       m_err);
`endif
    s_acc   = RSTN && v && !M_REQINV;
    s_win   = w;
    s_pop   = pop;
    s_stray = M_RSPV && (mq.size() == 0);
  end

  always @(posedge CLK) begin
    if (!RSTN) begin
      mq.delete();
      m_rr  = 1'b0;
      m_err = 1'b0;
    end else begin
      if (s_stray) m_err = 1'b1;
      if (s_pop) void'(mq.pop_front());
      if (s_acc) begin
        mq.push_back(s_win);
        m_rr = !s_win;
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    cyc();
    RSTN = 1'b1;
  endtask

  initial begin
    RSTN = 1'b0; F0_REQV = 1'b0; F1_REQV = 1'b0; F0_PC = 32'h0; F1_PC = 32'h0;
    M_REQINV = 1'b0; M_RSPV = 1'b0; M_RSPINV = 1'b0; M_INSTR = 32'h0;
    #1;
    F0_REQV = 1'b1;
    settle();
    chk("rst_mreqv", M_REQV, 1'b0);
    chk("rst_f0inv", F0_REQINV, 1'b1);
    cyc(); cyc();
    F0_REQV = 1'b0;
    RSTN = 1'b1;

    // Single requester
    F0_REQV = 1'b1; F0_PC = 32'h100;
    settle();
    chk("t1_mpc", M_PC, 32'h100);
    chk("t1_f0inv", F0_REQINV, 1'b0);
    cyc(); F0_REQV = 1'b0;
    cyc(); M_RSPV = 1'b1; M_INSTR = 32'hDEADBEEF;
    settle();
    chk("t1_f0rspv", F0_RSPV, 1'b1);
    chk("t1_f0instr", F0_INSTR, 32'hDEADBEEF);
    chk("t1_f1rspv", F1_RSPV, 1'b0);
    cyc(); M_RSPV = 1'b0;

    // Alternation with overlapped responses
    do_reset();
    F0_REQV = 1'b1; F1_REQV = 1'b1; F0_PC = 32'h0; F1_PC = 32'h1000; M_INSTR = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      M_RSPV = (i > 0);
      settle();
      chk("t2_mpc", M_PC, (i % 2) ? 32'h1000 : 32'h0);
      if (i > 0) chk("t2_f0rspv", F0_RSPV, ((i - 1) % 2) == 0);
      cyc();
    end
    F0_REQV = 1'b0; F1_REQV = 1'b0; M_RSPV = 1'b1;
    settle();
    chk("t2_last_f1rspv", F1_RSPV, 1'b1);
    cyc(); M_RSPV = 1'b0;

    // Memory stall
    do_reset();
    F0_REQV = 1'b1; F1_REQV = 1'b1; M_REQINV = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t3_f0inv", F0_REQINV, 1'b1);
      chk("t3_f1inv", F1_REQINV, 1'b1);
      chk("t3_mpc", M_PC, 32'h0);
      cyc();
    end
    M_REQINV = 1'b0;
    settle();
    chk("t3_grant_f0", F0_REQINV, 1'b0);
    cyc(); settle();
    chk("t3_grant_f1", M_PC, 32'h1000);
    cyc(); F0_REQV = 1'b0; F1_REQV = 1'b0;

    // Full FIFO, pop while full, then drain through the pointer wrap
    do_reset();
    F0_REQV = 1'b1; F0_PC = 32'h200; F1_PC = 32'h300;
    repeat (4) cyc();
    F1_REQV = 1'b1; M_RSPV = 1'b1;
    settle();
    chk("t4_full_mreqv", M_REQV, 1'b0);
    chk("t4_full_f0inv", F0_REQINV, 1'b1);
    chk("t4_full_f1inv", F1_REQINV, 1'b1);
    chk("t4_full_pop", F0_RSPV, 1'b1);
    cyc(); M_RSPV = 1'b0;
    settle();
    chk("t4_reaccept", M_REQV, 1'b1);
    chk("t4_rr_f1", M_PC, 32'h300);
    cyc(); F0_REQV = 1'b0; F1_REQV = 1'b0; M_RSPV = 1'b1;
    repeat (4) cyc();
    M_RSPV = 1'b0;

    // Invalid response to F1
    do_reset();
    F1_REQV = 1'b1; F1_PC = 32'h400;
    cyc(); F1_REQV = 1'b0; M_RSPV = 1'b1; M_RSPINV = 1'b1;
    settle();
    chk("t5_f1rspv", F1_RSPV, 1'b1);
    chk("t5_f1rspinv", F1_RSPINV, 1'b1);
    chk("t5_f0rspv", F0_RSPV, 1'b0);
    cyc(); M_RSPV = 1'b0; M_RSPINV = 1'b0;

    // Reset with requests outstanding, then a late response
    do_reset();
    F0_REQV = 1'b1; F1_REQV = 1'b1; F0_PC = 32'h500; F1_PC = 32'h600;
    cyc(); cyc();
    F0_REQV = 1'b0; F1_REQV = 1'b0;
    do_reset();
    M_RSPV = 1'b1;
    settle();
    chk("t6_f0rspv", F0_RSPV, 1'b0);
    chk("t6_f1rspv", F1_RSPV, 1'b0);
    cyc(); M_RSPV = 1'b0;
`ifdef FETCH_MEM_ARB_ERR_EN
    settle();
    chk("t6_err", ERR, 1'b1);
`endif
    F0_REQV = 1'b1; F1_REQV = 1'b1;
    settle();
    chk("t6_first_f0", M_PC, 32'h500);
    cyc(); F0_REQV = 1'b0; F1_REQV = 1'b0;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_mem_arb.md
Name: fetch_mem_arb

Overview:
- Shares one instruction-memory port between two fetch requesters using the fetch/mem request-response protocol: REQV/PC/REQINV requests; RSPV/RSPINV/INSTR responses.
- Sits between two fetch units (for example, two hart fetchers, or a fetcher plus a prefetcher) and a single memory slave.
- Round-robin arbitration. Supports up to OUTST in-order outstanding requests.
- Routes each response back to its originating requester through an ID FIFO.

Parameters:
- OUTST, 4, maximum outstanding accepted-but-unanswered requests (1..16). Sets the ID FIFO depth.
- PCW, 32, PC width.
- IW, 32, instruction width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RSTN  in  1  synchronous active-low reset.
- F0_REQV  in  1  requester 0 request valid.
- F0_PC  in  PCW  requester 0 request PC.
- F0_REQINV  out  1  requester 0 stall; request not accepted this cycle.
- F0_RSPV  out  1  requester 0 response valid.
- F0_RSPINV  out  1  requester 0 response invalid flag.
- F0_INSTR  out  IW  requester 0 instruction.
- F1_REQV, F1_PC, F1_REQINV, F1_RSPV, F1_RSPINV, F1_INSTR  same as F0_*, for requester 1.
- M_REQV  out  1  memory request valid.
- M_PC  out  PCW  memory request PC.
- M_REQINV  in  1  memory stall.
- M_RSPV  in  1  memory response valid.
- M_RSPINV  in  1  memory response invalid flag.
- M_INSTR  in  IW  memory instruction.

Behaviour:
- Handshake: a request is accepted in a cycle where REQV=1 and REQINV=0 on the same side. The requester holds REQV/PC stable while stalled.
- Responses: one per accepted request, in order. A response is a single-cycle RSPV pulse. RSPINV is meaningful only with RSPV.
- State:
  - rr pointer (1 bit): preferred requester.
  - ID FIFO: OUTST entries of 1 bit, with read/write pointers that wrap at OUTST.
  - count: width $clog2(OUTST+1).
- Reset (RSTN=0 at edge): rr=0, FIFO empty, count=0.
- While RSTN=0, outputs are forced combinationally: M_REQV=0, F0_REQINV=F1_REQINV=1, F0_RSPV=F1_RSPV=0.
- Grant (combinational, zero latency):
  - full = (count==OUTST).
  - If full: M_REQV=0 and both REQINV=1.
  - Else if only one requester has REQV=1, it wins.
  - Else if both have REQV=1, the rr requester wins.
  - M_REQV = winner's REQV; M_PC = winner's PC (F0_PC when there is no winner).
  - Winner's REQINV = M_REQINV. Loser's REQINV = 1. A non-requesting side's REQINV = 1.
- Accept (M_REQV & ~M_REQINV & ~full):
  - Push winner ID into the FIFO.
  - rr becomes the non-winner.
  - rr is unchanged on stalled or idle cycles.
- Response (M_RSPV & ~empty):
  - Pop the head ID.
  - Fx_RSPV = 1 for the head ID only. The other side gets RSPV=0.
  - Fx_RSPINV = M_RSPINV for the head ID, 0 otherwise.
- F0_INSTR = F1_INSTR = M_INSTR unconditionally. The data is qualified by RSPV only.
- Boundary conditions:
  - Simultaneous push and pop: count unchanged; both pointers advance.
  - Full with a pop in the same cycle: push is still blocked that cycle. full is based on registered count, so there is no combinational path from M_RSPV to REQINV.
  - M_RSPV while empty: the response is dropped, no Fx_RSPV is asserted, and state is unchanged.
  - Reset mid-operation: outstanding IDs are discarded. Late memory responses after reset land on an empty FIFO and are dropped.
  - Pointer wrap: write and read pointers return to 0 after OUTST-1, so non-power-of-2 OUTST is legal.

Optional Feature:
- Macro: FETCH_MEM_ARB_ERR_EN.
- Defined:
  - Adds output port ERR (1 bit), a sticky register.
  - ERR resets to 0 and is set on the cycle after any M_RSPV while the FIFO is empty.
  - ERR is cleared only by reset.
- Not defined: no ERR port. Stray responses are silently dropped.

Test Plan:
- Single requester: F0_REQV=1, PC=0x100, M_REQINV=0; M_RSPV two cycles later with INSTR=0xDEADBEEF -> M_PC=0x100 the same cycle, F0_RSPV=1 with F0_INSTR=0xDEADBEEF, F1_RSPV=0.
- Both request continuously, no stall (F0 PC=0x0, F1 PC=0x1000): grants alternate F0,F1,F0,F1 starting with F0 after reset. Responses return in order to F0,F1,F0,F1.
- Memory stall: both request, M_REQINV=1 for 3 cycles -> F0_REQINV=F1_REQINV=1, rr stays 0. The stall clears and F0 is granted first.
- Full: OUTST=4, four accepts with no responses -> fifth cycle M_REQV=0 and both REQINV=1. One M_RSPV pops, and the next cycle accepts again.
- Invalid response: one F1 request outstanding, M_RSPV=1 with M_RSPINV=1 -> F1_RSPV=1, F1_RSPINV=1, F0_RSPV=0.
- Reset mid-operation: 2 outstanding, then RSTN=0 for one cycle, then M_RSPV=1 -> no Fx_RSPV. With FETCH_MEM_ARB_ERR_EN, ERR=1 the next cycle; after reset, rr=0 and F0 is granted first.
